// File: rtl/wide_adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wide_adder_seq_pkg
// Description : Shared constants, FSM encoding and index-width helper for
//               the sequential wide adder.
// Revision    : 1.0 - initial release
// ============================================================================
package wide_adder_seq_pkg;

    localparam int c_slice_w = 16;

    typedef logic [1:0] state_t;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // Slice index register width; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_16bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_16bit
// Description : 16-bit ripple-carry adder built from gate-level full adders.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_16bit
    import wide_adder_seq_pkg::*;
(
    input  logic [c_slice_w-1:0] a,
    input  logic [c_slice_w-1:0] b,
    input  logic                 ci,
    output logic [c_slice_w-1:0] sum,
    output logic                 co
);

    logic [c_slice_w:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < c_slice_w; i++) begin : g_bit
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co = w_c[c_slice_w];

endmodule
`default_nettype wire

// File: rtl/wide_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : wide_adder_seq
// Description : Multi-cycle wide adder; one 16-bit slice per clock through a
//               single adder_16bit, LSB slice first, with valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_adder_seq
    import wide_adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [c_slice_w*WORDS-1:0] a,
    input  logic [c_slice_w*WORDS-1:0] b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [c_slice_w*WORDS-1:0] y,
    output logic                       co,
    output logic                       busy
);

    localparam int                 c_w        = c_slice_w * WORDS;
    localparam int                 c_idx_w    = idx_width(WORDS);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORDS - 1);

    state_t               r_state;
    logic [c_w-1:0]       r_a;
    logic [c_w-1:0]       r_b;
    logic                 r_carry;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_out_valid;
    logic                 r_co;
    logic [c_slice_w-1:0] r_y_slice [WORDS];

    logic [c_slice_w-1:0] w_a_slice;
    logic [c_slice_w-1:0] w_b_slice;
    logic [c_slice_w-1:0] w_sum;
    logic                 w_sum_co;

    // Operand slice mux driven by the current slice index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_a_slice = r_a[i*c_slice_w +: c_slice_w];
                w_b_slice = r_b[i*c_slice_w +: c_slice_w];
            end
        end
    end

    adder_16bit u_adder (
        .a   (w_a_slice),
        .b   (w_b_slice),
        .ci  (r_carry),
        .sum (w_sum),
        .co  (w_sum_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_co        <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_carry <= w_sum_co;
                    if (r_idx == c_last_idx) begin
                        r_co        <= w_sum_co;
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end else begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Each result slice is written only on its own RUN cycle.
    for (genvar i = 0; i < WORDS; i++) begin : g_slice
        always_ff @(posedge clk) begin
            if (rst) begin
                r_y_slice[i] <= '0;
            end else if (r_state == c_st_run && r_idx == c_idx_w'(i)) begin
                r_y_slice[i] <= w_sum;
            end
        end
        assign y[i*c_slice_w +: c_slice_w] = r_y_slice[i];
    end

    assign in_ready  = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign out_valid = r_out_valid;
    assign co        = r_co;

endmodule
`default_nettype wire

// File: tb/tb_wide_adder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wide_adder_seq
// Description : Directed and random checks of wide_adder_seq at WORDS=4 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_adder_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] y;
    logic        co;
    logic        busy;

    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [15:0] a1 = '0;
    logic [15:0] b1 = '0;
    logic        cin1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    logic [15:0] y1;
    logic        co1;
    logic        busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wide_adder_seq #(.WORDS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .co        (co),
        .busy      (busy)
    );

    wide_adder_seq #(.WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .y         (y1),
        .co        (co1),
        .busy      (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for out_valid on the WORDS=4 instance; returns cycles waited.
    task automatic wait_out4(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Offer one operand set to the WORDS=4 instance, check latency and result, drain it.
    task automatic op4(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                       input logic tcin, input logic [63:0] ey, input logic eco);
        int lat;
        a = ta; b = tb_; cin = tcin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = '1; b = '1; cin = 1'b1;
        chk({tag, "_busy"}, 65'(busy), 65'(1'b1));
        wait_out4(lat);
        chk({tag, "_latency"}, 65'(lat), 65'(4));
        chk({tag, "_y"}, 65'(y), 65'(ey));
        chk({tag, "_co"}, 65'(co), 65'(eco));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, 65'({in_ready, out_valid}), 65'(2'b10));
    endtask

    initial begin
        int          lat;
        int          results;
        logic [64:0] model;
        logic [16:0] model1;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 65'(out_valid), 65'(1'b0));
        chk("rst_in_ready", 65'(in_ready), 65'(1'b1));
        chk("rst_busy", 65'(busy), 65'(1'b0));
        chk("rst_y", 65'(y), 65'(0));
        chk("rst_co", 65'(co), 65'(1'b0));

        // Directed carry patterns
        op4("cross", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0);
        op4("chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
        op4("mixed", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 64'h1, 1'b1);

        // Backpressure with a new operand set waiting upstream
        a = 64'd1; b = 64'd2; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out4(lat);
        chk("bp_latency", 65'(lat), 65'(4));
        a = 64'd100; b = 64'd200; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_y", 65'(y), 65'(3));
            chk("bp_hold_flags", 65'({co, in_ready, out_valid}), 65'(3'b001));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", 65'({in_ready, out_valid, busy}), 65'(3'b100));
        tick();
        in_valid = 1'b0;
        chk("bp_accept", 65'({in_ready, busy}), 65'(2'b01));
        wait_out4(lat);
        chk("bp_latency2", 65'(lat), 65'(4));
        chk("bp_y2", 65'(y), 65'(300));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a run
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", 65'({in_ready, out_valid, busy, co}), 65'(4'b1000));
        chk("midrst_y", 65'(y), 65'(0));
        op4("after_rst", 64'd5, 64'd7, 1'b1, 64'd13, 1'b0);

        // Random traffic, WORDS=4
        results = 0;
        for (int n = 0; n < 1000; n++) begin
            int waited;
            repeat ($urandom_range(0, 2)) tick();
            a = {$urandom(), $urandom()};
            b = (n % 8 == 0) ? ~a : {$urandom(), $urandom()};
            cin = 1'($urandom_range(0, 1));
            model = {1'b0, a} + {1'b0, b} + 65'(cin);
            in_valid = 1'b1;
            waited = 0;
            while (!in_ready && waited < 20) begin
                tick();
                waited++;
            end
            tick();
            in_valid = 1'b0;
            waited = 0;
            while (waited < 50) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) break;
                tick();
                waited++;
            end
            if (waited >= 50) chk("rnd4_timeout", 65'(0), 65'(1));
            chk("rnd4_sum", {co, y}, model);
            results++;
            tick();
            out_ready = 1'b0;
            if (out_valid) chk("rnd4_dup", 65'(out_valid), 65'(1'b0));
        end
        chk("rnd4_count", 65'(results), 65'(1000));

        // Random traffic, WORDS=1
        results = 0;
        for (int n = 0; n < 1000; n++) begin
            int waited;
            repeat ($urandom_range(0, 2)) tick();
            a1 = 16'($urandom());
            b1 = (n % 8 == 0) ? ~a1 : 16'($urandom());
            cin1 = 1'($urandom_range(0, 1));
            model1 = {1'b0, a1} + {1'b0, b1} + 17'(cin1);
            in_valid1 = 1'b1;
            waited = 0;
            while (!in_ready1 && waited < 20) begin
                tick();
                waited++;
            end
            tick();
            in_valid1 = 1'b0;
            waited = 0;
            while (waited < 50) begin
                out_ready1 = 1'($urandom_range(0, 1));
                if (out_valid1 && out_ready1) break;
                tick();
                waited++;
            end
            if (waited >= 50) chk("rnd1_timeout", 65'(0), 65'(1));
            chk("rnd1_sum", 65'({co1, y1}), 65'(model1));
            results++;
            tick();
            out_ready1 = 1'b0;
            if (out_valid1) chk("rnd1_dup", 65'(out_valid1), 65'(1'b0));
        end
        chk("rnd1_count", 65'(results), 65'(1000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wide_adder_seq.md
Name: wide_adder_seq

Overview:
Multi-cycle wide adder. Computes a + b + cin on operands of 16*WORDS bits by stepping one 16-bit slice per cycle through a single adder_16bit instance, least-significant slice first, with the carry held in a register between slices. It sits directly upstream of the 16-bit adder and drives its operands and carry-in. Valid/ready handshakes on input and output let datapath blocks feed it and drain it.

Parameters:
WORDS, 4, number of 16-bit slices; total operand width W = 16*WORDS; legal range 1..16.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand set offered
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  W  operand A
b  input  W  operand B
cin  input  1  carry-in to slice 0
out_valid  output  1  result y/co valid
out_ready  input  1  consumer takes result
y  output  W  registered sum
co  output  1  registered carry-out of the top slice
busy  output  1  high in RUN or DONE

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. The polarity and synchronicity are fixed.
- Reset values: state=IDLE, out_valid=0, y=0, co=0, busy=0, in_ready=1 (in_ready is decoded from state), internal carry=0, slice index=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid && in_ready: latch a and b into operand registers, carry<=cin, idx<=0, go to RUN. Without in_valid, stay in IDLE.
  - RUN: in_ready=0. Each cycle the adder sees a_reg[16*idx +: 16], b_reg[16*idx +: 16] and carry. On the edge: y[16*idx +: 16]<=sum, carry<=adder Co, idx<=idx+1. When idx==WORDS-1: co<=adder Co, out_valid<=1, go to DONE.
  - DONE: y, co and out_valid are held stable. On out_valid && out_ready: out_valid<=0, go to IDLE. in_ready stays low for this cycle, so there is no accept in the same cycle as the output handshake.
- Latency: operands accepted on edge T give out_valid high after edge T+WORDS (WORDS=4 means 4 cycles).
- Throughput: one operation per WORDS+2 cycles when out_ready is held high.
- Changes on a, b or cin after acceptance are ignored; only the latched copies are used.
- y bits of slices not yet computed keep their previous values during RUN. Consumers may only sample y while out_valid=1.
- Index register width is max(1, clog2(WORDS)). WORDS=1 gives a single RUN cycle and idx never increments past 0.
- Wrap-around: the sum is modulo 2^W and the overflow carry appears only on co. No signed overflow flag.
- Reset mid-operation (RUN or DONE): the operation is aborted and all reset values apply on the next cycle. No partial result is signalled.
- in_valid asserted while busy is not accepted and is not queued; the upstream block holds it.
- out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Shared package: constant SLICE_W=16; FSM state enum {IDLE, RUN, DONE}; helper function for the index width.
- One sub-module: the existing adder_16bit, instantiated once as the slice datapath. No behavioural "+" is used.
- FSM, operand registers and result registers live in wide_adder_seq.

Test Plan:
- Reset: assert rst for 2 cycles, then release -> out_valid=0, in_ready=1, busy=0, y=0, co=0.
- WORDS=4: a=64'h0000_0000_0000_FFFF, b=64'h1, cin=0 -> y=64'h0000_0000_0001_0000, co=0; out_valid rises exactly 4 cycles after accept.
- Full carry chain: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> y=0, co=1. Mixed: a=64'h8000_0000_0000_0000, b=64'h8000_0000_0000_0001, cin=0 -> y=64'h1, co=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> y and co stable, in_ready=0, nothing accepted. Raise out_ready -> IDLE next cycle; the new operands are accepted on the following edge.
- Reset after 2 RUN slices -> next cycle state IDLE, out_valid=0, y=0. A following operation a=5, b=7, cin=1 -> y=13, co=0.
- Random: 1000 operations at WORDS=1 and WORDS=4, with random in_valid/out_ready gaps, checked against the model {co,y} = a+b+cin; no lost or duplicated results.
